// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, writeback select / load-align encodings and
//               small helpers for the MIPS core writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DEF_DW  = 32;
    localparam int DEF_RAW = 5;

    // Load alignment operations carried down the pipe from decode.
    typedef enum logic [2:0] {
        ALIGN_LW   = 3'b000,
        ALIGN_LB   = 3'b001,
        ALIGN_LBU  = 3'b010,
        ALIGN_LH   = 3'b011,
        ALIGN_LHU  = 3'b100,
        ALIGN_LWL  = 3'b101,
        ALIGN_LWR  = 3'b110,
        ALIGN_RSVD = 3'b111
    } align_op_e;

    // Source of the register-file write data.
    typedef enum logic [1:0] {
        WBSEL_RESULT = 2'b00,
        WBSEL_LOAD   = 2'b01,
        WBSEL_HI     = 2'b10,
        WBSEL_LO     = 2'b11
    } wbsel_e;

    localparam logic [3:0] MASK_ALL  = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    // Physical byte lane in the memory word holding the addressed byte.
    // Big-endian reverses the lane order within the word.
    function automatic logic [1:0] byte_lane(input logic [1:0] offset,
                                             input logic       big_endian);
        return offset ^ {2{big_endian}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_wb_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb_pipe_if
// Description : MEM -> WB handshake and register-file write bundle. The
//               master side is the MEM stage / hazard unit, the slave side is
//               the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_wb_pipe_if
    import cpu_pkg::*;
#(
    parameter int RAW = DEF_RAW,
    parameter int DW  = DEF_DW
) ();

    // Control from the hazard unit / core.
    logic           big_endian;
    logic           stall;
    logic           flush;
    logic           irqn;

    // MEM stage instruction.
    logic           m_valid;
    logic [RAW-1:0] m_rd;
    logic           m_rd_we;
    logic [1:0]     m_wbdata_sel;
    logic [2:0]     m_align_op;
    logic [1:0]     m_dmem_offset;
    logic [DW-1:0]  m_result;
    logic [DW-1:0]  m_rdata;
    logic [1:0]     m_hilo_we;
    logic [DW-1:0]  m_mul_hi;
    logic [DW-1:0]  m_mul_lo;

    // Register-file write port and architectural state.
    logic           rf_we;
    logic [RAW-1:0] rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic [3:0]     rf_wmask;
    logic [DW-1:0]  hi_q;
    logic [DW-1:0]  lo_q;

    // Forwarding toward EX.
    logic           fwd_valid;
    logic [RAW-1:0] fwd_rd;
    logic [DW-1:0]  fwd_data;

    logic           wb_valid;

    modport master (
        output big_endian, stall, flush, irqn,
        output m_valid, m_rd, m_rd_we, m_wbdata_sel, m_align_op, m_dmem_offset,
        output m_result, m_rdata, m_hilo_we, m_mul_hi, m_mul_lo,
        input  rf_we, rf_waddr, rf_wdata, rf_wmask, hi_q, lo_q,
        input  fwd_valid, fwd_rd, fwd_data, wb_valid
    );

    modport slave (
        input  big_endian, stall, flush, irqn,
        input  m_valid, m_rd, m_rd_we, m_wbdata_sel, m_align_op, m_dmem_offset,
        input  m_result, m_rdata, m_hilo_we, m_mul_hi, m_mul_lo,
        output rf_we, rf_waddr, rf_wdata, rf_wmask, hi_q, lo_q,
        output fwd_valid, fwd_rd, fwd_data, wb_valid
    );

endinterface
`default_nettype wire

// File: rtl/cpu_wb_align.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb_align
// Description : Combinational load-data alignment. Extracts / extends the
//               addressed byte or halfword and produces LWL/LWR partial-word
//               data with the matching byte-lane write mask.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_wb_align
    import cpu_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [1:0]    offset_i,
    input  logic          big_endian_i,
    input  logic [2:0]    align_op_i,
    input  logic [DW-1:0] load_data_i,
    output logic [DW-1:0] dout_o,
    output logic [3:0]    write_mask_o
);

    logic [1:0]  lane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    align_op_e   op;

    assign lane   = byte_lane(offset_i, big_endian_i);
    assign byte_v = load_data_i[{lane, 3'b000} +: 8];
    // Halfword loads are assumed aligned; only the upper lane bit matters.
    assign half_v = load_data_i[{lane[1], 4'b0000} +: 16];
    assign op     = align_op_e'(align_op_i);

    // Select aligned data and lane mask. LWL fills the register from the top
    // down to the addressed lane, LWR from the bottom up; the register file
    // merges the untouched lanes using the mask.
    always_comb begin
        dout_o       = load_data_i;
        write_mask_o = MASK_ALL;
        case (op)
            ALIGN_LB:  dout_o = {{(DW-8){byte_v[7]}}, byte_v};
            ALIGN_LBU: dout_o = {{(DW-8){1'b0}}, byte_v};
            ALIGN_LH:  dout_o = {{(DW-16){half_v[15]}}, half_v};
            ALIGN_LHU: dout_o = {{(DW-16){1'b0}}, half_v};
            ALIGN_LWL: begin
                dout_o       = load_data_i << {~lane, 3'b000};
                write_mask_o = MASK_ALL << ~lane;
            end
            ALIGN_LWR: begin
                dout_o       = load_data_i >> {lane, 3'b000};
                write_mask_o = MASK_ALL >> lane;
            end
            default: begin
                dout_o       = load_data_i;
                write_mask_o = MASK_ALL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb_pipe
// Description : Registered writeback stage: MEM/WB pipeline register with
//               stall/flush/kill, architectural HI/LO, load alignment, the
//               register-file write port and a forwarding port toward EX.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_wb_pipe
    import cpu_pkg::*;
#(
    parameter int RAW     = DEF_RAW,
    parameter int DW      = DEF_DW,
    parameter bit HILO_EN = 1'b1,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    cpu_wb_pipe_if.slave bus
);

    // The alignment datapath is built around 4 byte lanes of a 32-bit word.
    if (DW != 32) begin : g_dw_check
        $error("cpu_wb_pipe: DW must be 32");
    end

    // MEM/WB pipeline register.
    logic           wb_valid_q;
    logic [RAW-1:0] wb_rd_q;
    logic           wb_rd_we_q;
    logic [1:0]     wb_sel_q;
    logic [2:0]     wb_align_op_q;
    logic [1:0]     wb_offset_q;
    logic [DW-1:0]  wb_result_q;
    logic [DW-1:0]  wb_rdata_q;
    logic [1:0]     wb_hilo_we_q;
    logic [DW-1:0]  wb_mul_hi_q;
    logic [DW-1:0]  wb_mul_lo_q;

    logic           wb_valid_d;
    logic           capture;

    logic [DW-1:0]  hi_val;
    logic [DW-1:0]  lo_val;
    logic [DW-1:0]  load_data;
    logic [3:0]     load_mask;
    logic [DW-1:0]  wdata;
    logic [3:0]     wmask;
    logic           we;

    // Flush beats stall; an interrupt only kills an instruction being captured.
    assign capture    = !bus.flush && !bus.stall;
    assign wb_valid_d = bus.flush ? 1'b0
                      : bus.stall ? wb_valid_q
                      : (bus.m_valid & bus.irqn);

    // Pipeline register: valid always follows the priority rules, payload
    // only loads on a normal capture and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_rd_we_q    <= 1'b0;
            wb_sel_q      <= '0;
            wb_align_op_q <= '0;
            wb_offset_q   <= '0;
            wb_result_q   <= '0;
            wb_rdata_q    <= '0;
            wb_hilo_we_q  <= '0;
            wb_mul_hi_q   <= '0;
            wb_mul_lo_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            if (capture) begin
                wb_rd_q       <= bus.m_rd;
                wb_rd_we_q    <= bus.m_rd_we;
                wb_sel_q      <= bus.m_wbdata_sel;
                wb_align_op_q <= bus.m_align_op;
                wb_offset_q   <= bus.m_dmem_offset;
                wb_result_q   <= bus.m_result;
                wb_rdata_q    <= bus.m_rdata;
                wb_hilo_we_q  <= bus.m_hilo_we;
                wb_mul_hi_q   <= bus.m_mul_hi;
                wb_mul_lo_q   <= bus.m_mul_lo;
            end
        end
    end

    if (HILO_EN) begin : g_hilo
        logic [DW-1:0] hi_q;
        logic [DW-1:0] hi_d;
        logic [DW-1:0] lo_q;
        logic [DW-1:0] lo_d;

        // HI/LO retire on the edge the WB instruction leaves the stage, so a
        // stalled instruction commits exactly once.
        always_comb begin
            hi_d = hi_q;
            lo_d = lo_q;
            if (wb_valid_q && !bus.stall) begin
                if (wb_hilo_we_q[1]) hi_d = wb_mul_hi_q;
                if (wb_hilo_we_q[0]) lo_d = wb_mul_lo_q;
            end
        end

        // Architectural HI/LO state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hi_q <= '0;
                lo_q <= '0;
            end else begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
        end

        assign hi_val = hi_q;
        assign lo_val = lo_q;
    end else begin : g_no_hilo
        assign hi_val = '0;
        assign lo_val = '0;
    end

    cpu_wb_align #(
        .DW (DW)
    ) u_align (
        .offset_i     (wb_offset_q),
        .big_endian_i (bus.big_endian),
        .align_op_i   (wb_align_op_q),
        .load_data_i  (wb_rdata_q),
        .dout_o       (load_data),
        .write_mask_o (load_mask)
    );

    // Writeback data select; HI/LO already reflect every older instruction.
    always_comb begin
        wdata = wb_result_q;
        wmask = MASK_ALL;
        case (wbsel_e'(wb_sel_q))
            WBSEL_RESULT: wdata = wb_result_q;
            WBSEL_LOAD: begin
                wdata = load_data;
                wmask = load_mask;
            end
            WBSEL_HI:     wdata = hi_val;
            WBSEL_LO:     wdata = lo_val;
            default:      wdata = wb_result_q;
        endcase
    end

    // r0 is hardwired; a held instruction keeps strobing while stalled.
    assign we = wb_valid_q & wb_rd_we_q & (wb_rd_q != '0);

    assign bus.rf_we    = we;
    assign bus.rf_waddr = wb_rd_q;
    assign bus.rf_wdata = wdata;
    assign bus.rf_wmask = wb_valid_q ? wmask : MASK_NONE;
    assign bus.hi_q     = hi_val;
    assign bus.lo_q     = lo_val;
    assign bus.wb_valid = wb_valid_q;

    if (FWD_EN) begin : g_fwd
        assign bus.fwd_valid = we;
        assign bus.fwd_rd    = wb_rd_q;
        assign bus.fwd_data  = wdata;
    end else begin : g_no_fwd
        assign bus.fwd_valid = 1'b0;
        assign bus.fwd_rd    = '0;
        assign bus.fwd_data  = '0;
    end

endmodule
`default_nettype wire
